// File: rtl/uart_rx_frame.sv
// UART receive frame engine: oversampled start detect, 2-of-3 majority bit
// sampling, LSB-first deserialization, optional parity check and stop check.
// Optional build macro RX_SYNC_EN: adds a 2-flop input synchronizer on RX_IN
// (reset value 1), which delays all frame timing by two cycles.
module uart_rx_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic rx;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  // Two-stage synchronizer shift
  always_comb begin
    sync_d = {sync_q[0], RX_IN};
  end

  // Synchronizer flops idle high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= sync_d;
  end

  assign rx = sync_q[1];
`else
  assign rx = RX_IN;
`endif

  state_e                 state_q, state_d;
  logic [PRESC_W-1:0]     edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PRESC_W-1:0]     presc_q, presc_d;
  logic                   par_en_q, par_en_d;
  logic                   par_typ_q, par_typ_d;
  logic                   samp_a_q, samp_a_d;
  logic                   samp_b_q, samp_b_d;
  logic                   bit_val_q, bit_val_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  p_data_q, p_data_d;
  logic                   data_valid_q, data_valid_d;
  logic                   par_err_q, par_err_d;
  logic                   stp_err_q, stp_err_d;
  logic                   busy_q, busy_d;

  logic [PRESC_W-1:0]     half;
  logic                   last_edge;
  logic                   exp_par;

  assign half      = {1'b0, presc_q[PRESC_W-1:1]};
  assign last_edge = (edge_cnt_q == presc_q - PRESC_W'(1));
  assign exp_par   = par_typ_q ? ~^shift_q : ^shift_q;

  // Next-state, counters, sampling and output strobes
  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q + PRESC_W'(1);
    bit_cnt_d    = bit_cnt_q;
    presc_d      = presc_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    samp_a_d     = samp_a_q;
    samp_b_d     = samp_b_q;
    bit_val_d    = bit_val_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;

    // Three mid-bit samples; majority is registered right after the third
    if (state_q != S_IDLE) begin
      if (edge_cnt_q == half - PRESC_W'(1)) samp_a_d = rx;
      if (edge_cnt_q == half)               samp_b_d = rx;
      if (edge_cnt_q == half + PRESC_W'(1)) begin
        bit_val_d = (samp_a_q & samp_b_q) | (samp_a_q & rx) | (samp_b_q & rx);
      end
    end

    case (state_q)
      S_IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx) begin
          // The detect cycle itself is edge 0 of the start bit
          state_d    = S_START;
          edge_cnt_d = PRESC_W'(1);
          presc_d    = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_err_d  = 1'b0;
          stp_err_d  = 1'b0;
        end
      end

      S_START: begin
        if (last_edge) begin
          edge_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = bit_val_q ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (last_edge) begin
          edge_cnt_d                = '0;
          shift_d                   = shift_q >> 1;
          shift_d[DATA_WIDTH-1]     = bit_val_q;
          if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (last_edge) begin
          edge_cnt_d = '0;
          state_d    = S_STOP;
          if (bit_val_q != exp_par) par_err_d = 1'b1;
        end
      end

      S_STOP: begin
        if (last_edge) begin
          edge_cnt_d = '0;
          state_d    = S_IDLE;
          if (!bit_val_q) begin
            stp_err_d = 1'b1;
          end else if (!par_err_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d    = S_IDLE;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      presc_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      samp_a_q     <= 1'b1;
      samp_b_q     <= 1'b1;
      bit_val_q    <= 1'b1;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      presc_q      <= presc_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      samp_a_q     <= samp_a_d;
      samp_b_q     <= samp_b_d;
      bit_val_q    <= bit_val_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed frames, glitch, back-to-back, reset abort,
// randomized frames and an illegal-prescale recovery case.
`timescale 1ns/1ps
module tb_uart_rx_frame;

`ifdef RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         strobe_q[$];
  logic [7:0] strobe_data_q[$];
  logic [7:0] ref_pdata;

  typedef struct {
    logic [7:0] d;
    int         p;
    logic       pen;
    logic       ptyp;
    logic       pbit;
    logic       sbit;
  } vec_t;

  uart_rx_frame #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (rx_in),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .Prescale   (prescale),
    .P_DATA     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every cycle in which the strobe is high, with the byte presented
  always @(posedge clk) begin
    if (data_valid === 1'b1) begin
      strobe_q.push_back(cyc);
      strobe_data_q.push_back(p_data);
    end
  end

  // Serialize one frame starting at a negedge; returns after N*p cycles at a negedge.
  // Config inputs are scrambled once the frame is under way to exercise latching.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                            input logic ptyp, input logic pbit, input logic sbit,
                            output int t0, output logic ob, output logic ope,
                            output logic ose);
    logic bits[$];
    int   n;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(sbit);
    n        = bits.size();
    prescale = 6'(p);
    par_en   = pen;
    par_typ  = ptyp;
    t0       = cyc;
    ob = 1'b0; ope = 1'b1; ose = 1'b1;
    for (int k = 0; k < n * p; k++) begin
      rx_in = bits[k / p];
      if (k == SYNC_LAT + 1) begin
        ob       = busy;
        ope      = par_err;
        ose      = stp_err;
        prescale = 6'(8 << $urandom_range(0, 2));
        par_en   = 1'($urandom);
        par_typ  = 1'($urandom);
      end
      @(negedge clk);
    end
    rx_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({p_data, data_valid, par_err, stp_err, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold outputs got %h exp 000", {p_data, data_valid, par_err, stp_err, busy});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({p_data, data_valid, par_err, stp_err, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_release outputs got %h exp 000", {p_data, data_valid, par_err, stp_err, busy});
    end
    ref_pdata = 8'h00;
  endtask

  task automatic test_vectors();
    vec_t vt[4];
    int   t0, n0, nb;
    logic ob, ope, ose, ep, eperr, eserr, evalid;
    vt[0] = '{8'hA5, 8,  1'b1, 1'b0, 1'b0, 1'b1};
    vt[1] = '{8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[2] = '{8'h81, 8,  1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{8'h55, 8,  1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      n0 = strobe_q.size();
      send_frame(vt[i].d, vt[i].p, vt[i].pen, vt[i].ptyp, vt[i].pbit, vt[i].sbit, t0, ob, ope, ose);
      repeat (SYNC_LAT) @(negedge clk);
      ep     = (($countones(vt[i].d) % 2) == 1) ^ vt[i].ptyp;
      eperr  = vt[i].pen && (vt[i].pbit != ep);
      eserr  = !vt[i].sbit;
      evalid = !eperr && !eserr;
      if (evalid) ref_pdata = vt[i].d;
      nb     = vt[i].pen ? 11 : 10;
      checks++;
      if (ob !== 1'b1 || ope !== 1'b0 || ose !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_start busy/perr/serr got %b%b%b exp 100", i, ob, ope, ose);
      end
      checks++;
      if (data_valid !== evalid) begin
        errors++;
        $display("FAIL vec%0d_valid data_valid got %b exp %b", i, data_valid, evalid);
      end
      checks++;
      if (p_data !== ref_pdata) begin
        errors++;
        $display("FAIL vec%0d_pdata P_DATA got %h exp %h", i, p_data, ref_pdata);
      end
      checks++;
      if (par_err !== eperr || stp_err !== eserr || busy !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_flags perr/serr/busy got %b%b%b exp %b%b0", i, par_err, stp_err, busy, eperr, eserr);
      end
      @(negedge clk);
      checks++;
      if (data_valid !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_pulse data_valid got %b exp 0", i, data_valid);
      end
      checks++;
      if (strobe_q.size() - n0 !== (evalid ? 1 : 0)) begin
        errors++;
        $display("FAIL vec%0d_strobes count got %0d exp %0d", i, strobe_q.size() - n0, evalid ? 1 : 0);
      end else if (evalid) begin
        checks++;
        if (strobe_q[n0] - t0 !== nb * vt[i].p + SYNC_LAT) begin
          errors++;
          $display("FAIL vec%0d_timing strobe cycle got %0d exp %0d", i, strobe_q[n0] - t0, nb * vt[i].p + SYNC_LAT);
        end
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_glitch();
    int   n0;
    logic b7, b8;
    n0 = strobe_q.size();
    prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    b7 = 1'b0; b8 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rx_in = (k < 2) ? 1'b0 : 1'b1;
      if (k == 7 + SYNC_LAT) b7 = busy;
      if (k == 8 + SYNC_LAT) b8 = busy;
      @(negedge clk);
    end
    checks++;
    if (b7 !== 1'b1 || b8 !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy cycle7/cycle8 got %b%b exp 10", b7, b8);
    end
    checks++;
    if (strobe_q.size() != n0 || par_err !== 1'b0 || stp_err !== 1'b0 || p_data !== ref_pdata) begin
      errors++;
      $display("FAIL glitch_quiet strobes/perr/serr/pdata got %0d/%b/%b/%h exp 0/0/0/%h",
               strobe_q.size() - n0, par_err, stp_err, p_data, ref_pdata);
    end
  endtask

  task automatic test_back_to_back();
    int   n0, ta, tb;
    logic ob, ope, ose;
    n0 = strobe_q.size();
    send_frame(8'h12, 32, 1'b0, 1'b0, 1'b0, 1'b1, ta, ob, ope, ose);
    send_frame(8'h34, 32, 1'b0, 1'b0, 1'b0, 1'b1, tb, ob, ope, ose);
    repeat (SYNC_LAT + 2) @(negedge clk);
    ref_pdata = 8'h34;
    checks++;
    if (strobe_q.size() - n0 !== 2) begin
      errors++;
      $display("FAIL b2b_count strobes got %0d exp 2", strobe_q.size() - n0);
    end else begin
      checks++;
      if (strobe_q[n0 + 1] - strobe_q[n0] !== 320 || strobe_q[n0] - ta !== 320 + SYNC_LAT) begin
        errors++;
        $display("FAIL b2b_timing gap/first got %0d/%0d exp 320/%0d",
                 strobe_q[n0 + 1] - strobe_q[n0], strobe_q[n0] - ta, 320 + SYNC_LAT);
      end
      checks++;
      if (strobe_data_q[n0] !== 8'h12 || strobe_data_q[n0 + 1] !== 8'h34) begin
        errors++;
        $display("FAIL b2b_data bytes got %h %h exp 12 34", strobe_data_q[n0], strobe_data_q[n0 + 1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int   n0, t0;
    logic ob, ope, ose;
    prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    for (int k = 0; k < 8 * 4 + SYNC_LAT; k++) begin
      rx_in = (k < 8) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b1 || p_data !== ref_pdata) begin
      errors++;
      $display("FAIL rstmid_pre busy/pdata got %b/%h exp 1/%h", busy, p_data, ref_pdata);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({p_data, data_valid, par_err, stp_err, busy} !== 12'h000) begin
      errors++;
      $display("FAIL rstmid_async outputs got %h exp 000", {p_data, data_valid, par_err, stp_err, busy});
    end
    rx_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_pdata = 8'h00;
    repeat (4) @(negedge clk);
    n0 = strobe_q.size();
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, t0, ob, ope, ose);
    repeat (SYNC_LAT) @(negedge clk);
    ref_pdata = 8'h0F;
    checks++;
    if (data_valid !== 1'b1 || p_data !== 8'h0F) begin
      errors++;
      $display("FAIL rstmid_next valid/pdata got %b/%h exp 1/0f", data_valid, p_data);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (strobe_q.size() - n0 !== 1) begin
      errors++;
      $display("FAIL rstmid_strobes count got %0d exp 1", strobe_q.size() - n0);
    end
  endtask

  task automatic test_random();
    int         t0, n0, p, nb, gap;
    logic [7:0] d;
    logic       pen, ptyp, pbit, sbit, ep, eperr, eserr, evalid, ob, ope, ose;
    for (int i = 0; i < 30; i++) begin
      d      = 8'($urandom);
      p      = 8 << $urandom_range(0, 2);
      pen    = 1'($urandom);
      ptyp   = 1'($urandom);
      ep     = (($countones(d) % 2) == 1) ^ ptyp;
      pbit   = ep ^ ($urandom_range(0, 3) == 0);
      sbit   = !($urandom_range(0, 3) == 0);
      eperr  = pen && (pbit != ep);
      eserr  = !sbit;
      evalid = !eperr && !eserr;
      nb     = pen ? 11 : 10;
      n0     = strobe_q.size();
      send_frame(d, p, pen, ptyp, pbit, sbit, t0, ob, ope, ose);
      repeat (SYNC_LAT) @(negedge clk);
      if (evalid) ref_pdata = d;
      checks++;
      if (data_valid !== evalid || p_data !== ref_pdata) begin
        errors++;
        $display("FAIL rnd%0d_data valid/pdata got %b/%h exp %b/%h (p=%0d pen=%b)",
                 i, data_valid, p_data, evalid, ref_pdata, p, pen);
      end
      checks++;
      if (par_err !== eperr || stp_err !== eserr || ob !== 1'b1) begin
        errors++;
        $display("FAIL rnd%0d_flags perr/serr/busy1 got %b%b%b exp %b%b1", i, par_err, stp_err, ob, eperr, eserr);
      end
      @(negedge clk);
      checks++;
      if (strobe_q.size() - n0 !== (evalid ? 1 : 0) || data_valid !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_strobe count/level got %0d/%b exp %0d/0", i, strobe_q.size() - n0, data_valid, evalid ? 1 : 0);
      end else if (evalid && strobe_q[n0] - t0 !== nb * p + SYNC_LAT) begin
        errors++;
        $display("FAIL rnd%0d_timing strobe cycle got %0d exp %0d", i, strobe_q[n0] - t0, nb * p + SYNC_LAT);
      end
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic test_illegal_prescale();
    logic idle_seen;
    int   t0;
    logic ob, ope, ose;
    prescale = 6'd5; par_en = 1'b0; par_typ = 1'b0;
    idle_seen = 1'b0;
    for (int k = 0; k < 2000 && !idle_seen; k++) begin
      rx_in = (k < 3) ? 1'b0 : 1'b1;
      if (k > SYNC_LAT + 2 && busy === 1'b0) idle_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (!idle_seen) begin
      errors++;
      $display("FAIL illegal_presc busy still high got 1 exp 0 within 2000 cycles");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_pdata = 8'h00;
    repeat (4) @(negedge clk);
    send_frame(8'hC3, 16, 1'b1, 1'b0, 1'b0, 1'b1, t0, ob, ope, ose);
    repeat (SYNC_LAT) @(negedge clk);
    checks++;
    if (data_valid !== 1'b1 || p_data !== 8'hC3) begin
      errors++;
      $display("FAIL illegal_recover valid/pdata got %b/%h exp 1/c3", data_valid, p_data);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_illegal_prescale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
